// File: rtl/vid_resolution_detect_if.sv
// Video timing input stream and measurement results for vid_resolution_detect.
interface vid_resolution_detect_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 datavalid;
    logic                 hsync;
    logic                 vsync;
    logic [CNT_WIDTH-1:0] active_width;
    logic [CNT_WIDTH-1:0] active_height;
    logic [CNT_WIDTH-1:0] total_width;
    logic                 stable;
    logic                 res_change;
    logic                 overflow;

    modport master (
        output datavalid, hsync, vsync,
        input  active_width, active_height, total_width, stable, res_change, overflow
    );

    modport slave (
        input  datavalid, hsync, vsync,
        output active_width, active_height, total_width, stable, res_change, overflow
    );
endinterface

// File: rtl/vid_resolution_detect.sv
// Measures active width/height and line period per frame; flags a stable format
// once consecutive frames agree and pulses res_change when stability is lost.
module vid_resolution_detect #(
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned STABLE_COUNT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    vid_resolution_detect_if.slave vid
);
    localparam int unsigned MATCH_W = 4;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [MATCH_W-1:0]   MATCH_TGT = MATCH_W'(STABLE_COUNT);

    typedef enum logic {ST_UNARMED, ST_ARMED} state_t;

    state_t               state_q, state_n;
    logic                 hsync_q, hsync_n, vsync_q, vsync_n;
    logic [CNT_WIDTH-1:0] pix_q, pix_n, tot_q, tot_n, line_cnt_q, line_cnt_n;
    logic [CNT_WIDTH-1:0] frame_w_q, frame_w_n, frame_tot_q, frame_tot_n;
    logic                 first_q, first_n, incons_q, incons_n, ovf_q, ovf_n;
    logic                 prev_valid_q, prev_valid_n;
    logic [CNT_WIDTH-1:0] prev_w_q, prev_w_n, prev_h_q, prev_h_n, prev_t_q, prev_t_n;
    logic [MATCH_W-1:0]   match_q, match_n;
    logic [CNT_WIDTH-1:0] aw_q, aw_n, ah_q, ah_n, tw_q, tw_n;
    logic                 ovf_out_q, ovf_out_n, stable_q, stable_n, rc_q, rc_n;
    logic                 h_rise, v_rise, sat, good;

    // State register; everything clears asynchronously on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_UNARMED;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            pix_q        <= '0;
            tot_q        <= '0;
            line_cnt_q   <= '0;
            frame_w_q    <= '0;
            frame_tot_q  <= '0;
            first_q      <= 1'b0;
            incons_q     <= 1'b0;
            ovf_q        <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_w_q     <= '0;
            prev_h_q     <= '0;
            prev_t_q     <= '0;
            match_q      <= '0;
            aw_q         <= '0;
            ah_q         <= '0;
            tw_q         <= '0;
            ovf_out_q    <= 1'b0;
            stable_q     <= 1'b0;
            rc_q         <= 1'b0;
        end else begin
            state_q      <= state_n;
            hsync_q      <= hsync_n;
            vsync_q      <= vsync_n;
            pix_q        <= pix_n;
            tot_q        <= tot_n;
            line_cnt_q   <= line_cnt_n;
            frame_w_q    <= frame_w_n;
            frame_tot_q  <= frame_tot_n;
            first_q      <= first_n;
            incons_q     <= incons_n;
            ovf_q        <= ovf_n;
            prev_valid_q <= prev_valid_n;
            prev_w_q     <= prev_w_n;
            prev_h_q     <= prev_h_n;
            prev_t_q     <= prev_t_n;
            match_q      <= match_n;
            aw_q         <= aw_n;
            ah_q         <= ah_n;
            tw_q         <= tw_n;
            ovf_out_q    <= ovf_out_n;
            stable_q     <= stable_n;
            rc_q         <= rc_n;
        end
    end

    // Line counting, line close, then frame close (a coincident line close lands in the ending frame).
    always_comb begin
        state_n      = state_q;
        hsync_n      = vid.hsync;
        vsync_n      = vid.vsync;
        pix_n        = pix_q;
        tot_n        = tot_q;
        line_cnt_n   = line_cnt_q;
        frame_w_n    = frame_w_q;
        frame_tot_n  = frame_tot_q;
        first_n      = first_q;
        incons_n     = incons_q;
        ovf_n        = ovf_q;
        prev_valid_n = prev_valid_q;
        prev_w_n     = prev_w_q;
        prev_h_n     = prev_h_q;
        prev_t_n     = prev_t_q;
        match_n      = match_q;
        aw_n         = aw_q;
        ah_n         = ah_q;
        tw_n         = tw_q;
        ovf_out_n    = ovf_out_q;
        h_rise       = vid.hsync & ~hsync_q;
        v_rise       = vid.vsync & ~vsync_q;
        sat          = 1'b0;
        good         = 1'b0;

        if (h_rise) begin
            pix_n = CNT_WIDTH'(vid.datavalid);
        end else if (vid.datavalid) begin
            if (pix_q == CNT_MAX) sat = 1'b1;
            else                  pix_n = pix_q + CNT_ONE;
        end

        if (h_rise)                tot_n = CNT_ONE;
        else if (tot_q == CNT_MAX) sat = 1'b1;
        else                       tot_n = tot_q + CNT_ONE;

        if (h_rise) begin
            frame_tot_n = tot_q;
            if (pix_q != '0) begin
                if (line_cnt_q == CNT_MAX) sat = 1'b1;
                else                       line_cnt_n = line_cnt_q + CNT_ONE;
                if (!first_q) begin
                    frame_w_n = pix_q;
                    first_n   = 1'b1;
                end else if (pix_q != frame_w_q) begin
                    incons_n = 1'b1;
                end
            end
        end

        if (sat) ovf_n = 1'b1;

        if (v_rise) begin
            if (state_q == ST_UNARMED) begin
                state_n     = ST_ARMED;
                frame_w_n   = '0;
                frame_tot_n = '0;
            end else begin
                good = prev_valid_q && (frame_w_n == prev_w_q) && (line_cnt_n == prev_h_q) &&
                       (frame_tot_n == prev_t_q) && (line_cnt_n != '0) && !incons_n && !ovf_n;
                if (!good)                    match_n = '0;
                else if (match_q != MATCH_TGT) match_n = match_q + MATCH_W'(1);
                aw_n         = frame_w_n;
                ah_n         = line_cnt_n;
                tw_n         = frame_tot_n;
                ovf_out_n    = ovf_n;
                prev_w_n     = frame_w_n;
                prev_h_n     = line_cnt_n;
                prev_t_n     = frame_tot_n;
                prev_valid_n = 1'b1;
            end
            line_cnt_n = '0;
            first_n    = 1'b0;
            incons_n   = 1'b0;
            ovf_n      = 1'b0;
        end

        stable_n = (match_n == MATCH_TGT);
        rc_n     = stable_q & ~stable_n;
    end

    assign vid.active_width  = aw_q;
    assign vid.active_height = ah_q;
    assign vid.total_width   = tw_q;
    assign vid.overflow      = ovf_out_q;
    assign vid.stable        = stable_q;
    assign vid.res_change    = rc_q;
endmodule

// File: tb/tb_vid_resolution_detect.sv
// Bench for vid_resolution_detect: frame table with expected results, reset sequence,
// random frames; a line-list frame model checks both a 16-bit and a 4-bit instance every cycle.
module tb_vid_resolution_detect;
    localparam int S = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, hs, vs, dv;

    vid_resolution_detect_if #(.CNT_WIDTH(16)) vif16 ();
    vid_resolution_detect_if #(.CNT_WIDTH(4))  vif4 ();

    assign vif16.hsync = hs;
    assign vif16.vsync = vs;
    assign vif16.datavalid = dv;
    assign vif4.hsync = hs;
    assign vif4.vsync = vs;
    assign vif4.datavalid = dv;

    vid_resolution_detect #(.CNT_WIDTH(16), .STABLE_COUNT(S)) dut16 (.clk(clk), .rst(rst), .vid(vif16));
    vid_resolution_detect #(.CNT_WIDTH(4),  .STABLE_COUNT(S)) dut4  (.clk(clk), .rst(rst), .vid(vif4));

    int total = 0;
    int bad   = 0;

    typedef struct {
        int w; int p; int na; int nb; int voff; int odd; int sel;
        int aw; int ah; int tw; int ov; int st; int rc;
    } rec_t;

    // Frame model state: lines of the frame in progress, per-instance results.
    int q_w[$];
    int q_p[$];
    int m_max[2];
    int m_armed[2], m_pv[2], m_pw[2], m_ph[2], m_pt[2], m_match[2];
    int e_aw[2], e_ah[2], e_tw[2], e_ov[2], e_st[2], e_rc[2];
    int g_aw[2], g_ah[2], g_tw[2], g_ov[2], g_st[2], g_rc[2], g_rc1[2];

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_armed[k] = 0; m_pv[k] = 0; m_pw[k] = 0; m_ph[k] = 0; m_pt[k] = 0; m_match[k] = 0;
            e_aw[k] = 0; e_ah[k] = 0; e_tw[k] = 0; e_ov[k] = 0; e_st[k] = 0; e_rc[k] = 0;
        end
        q_w.delete();
        q_p.delete();
    endfunction

    // Evaluate the frame that just ended from its list of (width, period) lines.
    function automatic void model_close();
        for (int k = 0; k < 2; k++) begin
            int w, h, t, inc, ov, good, st;
            int mx;
            mx = m_max[k];
            w = 0; h = 0; t = 0; inc = 0; ov = 0;
            if (m_armed[k] == 0) begin
                m_armed[k] = 1;
            end else begin
                for (int i = 0; i < q_w.size(); i++) begin
                    int cw;
                    cw = imin(q_w[i], mx);
                    if (q_w[i] > mx || q_p[i] > mx) ov = 1;
                    if (cw != 0) begin
                        if (h == 0) w = cw;
                        else if (cw != w) inc = 1;
                        h++;
                    end
                end
                if (q_p.size() > 0) t = imin(q_p[q_p.size()-1], mx);
                if (h > mx) ov = 1;
                h = imin(h, mx);
                good = (m_pv[k] != 0 && w == m_pw[k] && h == m_ph[k] && t == m_pt[k] &&
                        h != 0 && inc == 0 && ov == 0) ? 1 : 0;
                m_match[k] = good ? imin(m_match[k] + 1, S) : 0;
                st = (m_match[k] == S) ? 1 : 0;
                e_rc[k] = (e_st[k] == 1 && st == 0) ? 1 : 0;
                e_st[k] = st;
                e_aw[k] = w; e_ah[k] = h; e_tw[k] = t; e_ov[k] = ov;
                m_pv[k] = 1; m_pw[k] = w; m_ph[k] = h; m_pt[k] = t;
            end
        end
        q_w.delete();
        q_p.delete();
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    task automatic cmp_inst(input int k, input int aw, input int ah, input int tw,
                            input int ov, input int st, input int rc);
        total++;
        if (aw != e_aw[k] || ah != e_ah[k] || tw != e_tw[k] || ov != e_ov[k] ||
            st != e_st[k] || rc != e_rc[k]) begin
            bad++;
            $display("FAIL model_dut%0d t=%0t: got aw=%0d ah=%0d tw=%0d ov=%0d st=%0d rc=%0d, required aw=%0d ah=%0d tw=%0d ov=%0d st=%0d rc=%0d",
                     k, $time, aw, ah, tw, ov, st, rc, e_aw[k], e_ah[k], e_tw[k], e_ov[k], e_st[k], e_rc[k]);
        end
    endtask

    task automatic check_model();
        cmp_inst(0, int'(vif16.active_width), int'(vif16.active_height), int'(vif16.total_width),
                 int'(vif16.overflow), int'(vif16.stable), int'(vif16.res_change));
        cmp_inst(1, int'(vif4.active_width), int'(vif4.active_height), int'(vif4.total_width),
                 int'(vif4.overflow), int'(vif4.stable), int'(vif4.res_change));
    endtask

    task automatic snap();
        g_aw[0] = int'(vif16.active_width); g_ah[0] = int'(vif16.active_height);
        g_tw[0] = int'(vif16.total_width);  g_ov[0] = int'(vif16.overflow);
        g_st[0] = int'(vif16.stable);       g_rc[0] = int'(vif16.res_change);
        g_aw[1] = int'(vif4.active_width);  g_ah[1] = int'(vif4.active_height);
        g_tw[1] = int'(vif4.total_width);   g_ov[1] = int'(vif4.overflow);
        g_st[1] = int'(vif4.stable);        g_rc[1] = int'(vif4.res_change);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e_rc[0] = 0;
        e_rc[1] = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            hs = 1'b0; vs = 1'b0; dv = 1'b0;
            tick();
            check_model();
        end
    endtask

    // One line: 1-cycle hsync at cycle 0, w valid samples from cycle 1, period p;
    // optional 2-cycle vsync starting at cycle voff.
    task automatic send_line(input int w, input int p, input int vsl, input int voff);
        for (int c = 0; c < p; c++) begin
            hs = (c == 0);
            vs = (vsl != 0) && (c == voff || c == voff + 1);
            dv = (c >= 1 && c <= w);
            tick();
            if (vsl != 0 && c == voff) begin
                model_close();
                snap();
            end
            if (vsl != 0 && c == voff + 1) begin
                g_rc1[0] = int'(vif16.res_change);
                g_rc1[1] = int'(vif4.res_change);
            end
            check_model();
        end
        hs = 1'b0; vs = 1'b0; dv = 1'b0;
        q_w.push_back(w);
        q_p.push_back(p);
    endtask

    // Blank lines first (the first carries vsync), then active lines; odd width on the second active line.
    task automatic send_frame(input rec_t r);
        for (int b = 0; b < r.nb; b++)
            send_line(0, r.p, (b == 0) ? 1 : 0, r.voff);
        for (int a = 0; a < r.na; a++)
            send_line((a == 1 && r.odd != 0) ? r.odd : r.w, r.p, (r.nb == 0 && a == 0) ? 1 : 0, r.voff);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t tab[13];
        rec_t nf;
        rec_t rr;
        int k;

        //           w   p  na nb vo odd sel | aw ah tw ov st rc  (seen at this frame's vsync)
        tab[0]  = '{ 8, 12, 5, 2, 0, 0, 0,    0, 0, 0, 0, 0, 0};
        tab[1]  = '{ 8, 12, 5, 2, 0, 0, 0,    8, 5, 12, 0, 0, 0};
        tab[2]  = '{ 8, 12, 5, 2, 1, 0, 0,    8, 5, 12, 0, 0, 0};
        tab[3]  = '{ 8, 12, 5, 2, 0, 0, 0,    8, 5, 12, 0, 1, 0};
        tab[4]  = '{10, 12, 5, 2, 0, 0, 0,    8, 5, 12, 0, 1, 0};
        tab[5]  = '{ 8, 12, 5, 2, 0, 7, 0,   10, 5, 12, 0, 0, 1};
        tab[6]  = '{ 8, 12, 5, 2, 2, 0, 0,    8, 5, 12, 0, 0, 0};
        tab[7]  = '{ 8, 12, 5, 2, 0, 0, 0,    8, 5, 12, 0, 0, 0};
        tab[8]  = '{ 8, 12, 5, 2, 0, 0, 0,    8, 5, 12, 0, 1, 0};
        tab[9]  = '{20, 24, 3, 1, 0, 0, 0,    8, 5, 12, 0, 1, 0};
        tab[10] = '{20, 24, 3, 1, 0, 0, 1,   15, 3, 15, 1, 0, 1};
        tab[11] = '{20, 24, 3, 1, 1, 0, 1,   15, 3, 15, 1, 0, 0};
        tab[12] = '{20, 24, 3, 1, 0, 0, 1,   15, 3, 15, 1, 0, 0};
        nf      = '{ 8, 12, 5, 2, 0, 0, 0,    0, 0, 0, 0, 0, 0};

        m_max[0] = 65535;
        m_max[1] = 15;
        model_reset();
        rst = 1'b1; hs = 1'b0; vs = 1'b0; dv = 1'b0;
        idle(3);
        chk("reset_aw", int'(vif16.active_width), 0);
        chk("reset_stable", int'(vif16.stable), 0);
        rst = 1'b0;
        idle(3);

        for (int i = 0; i < 13; i++) begin
            send_frame(tab[i]);
            k = tab[i].sel;
            chk($sformatf("tab%0d_aw", i), g_aw[k], tab[i].aw);
            chk($sformatf("tab%0d_ah", i), g_ah[k], tab[i].ah);
            chk($sformatf("tab%0d_tw", i), g_tw[k], tab[i].tw);
            chk($sformatf("tab%0d_ov", i), g_ov[k], tab[i].ov);
            chk($sformatf("tab%0d_st", i), g_st[k], tab[i].st);
            chk($sformatf("tab%0d_rc", i), g_rc[k], tab[i].rc);
            chk($sformatf("tab%0d_rc_next", i), g_rc1[k], 0);
        end

        // Regain stability, then assert rst partway through a frame.
        for (int i = 0; i < 5; i++) send_frame(nf);
        send_line(0, 12, 1, 0);
        send_line(8, 12, 0, 0);
        send_line(8, 12, 0, 0);
        chk("pre_reset_stable", int'(vif16.stable), 1);
        rst = 1'b1;
        #1;
        chk("rst_now_aw", int'(vif16.active_width), 0);
        chk("rst_now_ah", int'(vif16.active_height), 0);
        chk("rst_now_tw", int'(vif16.total_width), 0);
        chk("rst_now_st", int'(vif16.stable), 0);
        chk("rst_now_rc", int'(vif16.res_change), 0);
        chk("rst_now_ov", int'(vif4.overflow), 0);
        model_reset();
        idle(2);
        rst = 1'b0;
        idle(3);
        send_frame(nf);
        chk("rearm_aw", g_aw[0], 0);
        chk("rearm_st", g_st[0], 0);
        send_frame(nf);
        chk("resume_aw", g_aw[0], 8);
        chk("resume_ah", g_ah[0], 5);
        chk("resume_tw", g_tw[0], 12);
        chk("resume_st", g_st[0], 0);

        // Random frame formats, each repeated a few times so stability is reached and lost.
        rr = nf;
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) begin
                rr.w  = $urandom_range(1, 12);
                rr.p  = rr.w + 2 + $urandom_range(0, 3);
                rr.na = $urandom_range(1, 4);
                rr.nb = $urandom_range(0, 2);
            end
            rr.voff = $urandom_range(0, imin(3, rr.p - 2));
            rr.odd  = ($urandom_range(0, 5) == 0 && rr.na >= 2) ? rr.w + 1 : 0;
            send_frame(rr);
        end
        send_frame(nf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
